// File: rtl/pmips_arb_pkg.sv
// rtl/pmips_arb_pkg.sv - shared types and constants for the PMIPS memory arbiter
package pmips_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Counter width able to hold 0..v; never narrower than one bit.
  function automatic int clog2_p1(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  localparam int MEM_LATENCY_DFLT = 1;
  localparam int WAIT_CNT_W       = $clog2(MEM_LATENCY_DFLT + 1);

endpackage

// File: rtl/pmips_arb_prio.sv
// rtl/pmips_arb_prio.sv - data-first priority with bounded IF starvation
module pmips_arb_prio
  import pmips_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 2,
  parameter int CNT_W        = clog2_p1(STARVE_LIMIT)
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output logic [CNT_W-1:0] starve_nxt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic if_wins;

  assign if_wins = if_req && (!d_req || ((STARVE_LIMIT > 0) && (starve_cnt == LIMIT)));
  assign grant   = if_wins ? GNT_IF : GNT_D;

  // Value to store when a grant is made this cycle.
  always_comb begin
    starve_nxt = '0;
    if (!if_wins && if_req)
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pmips_mem_arbiter.sv
// rtl/pmips_mem_arbiter.sv - IF/data arbiter for one fixed-latency unified memory
// Optional stall performance counters built when PMIPS_ARB_PERF_EN is defined.
module pmips_mem_arbiter
  import pmips_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic [15:0]       perf_if_stall_cnt,
  output logic [15:0]       perf_d_stall_cnt
);

  localparam int WAIT_W = clog2_p1(MEM_LATENCY);
  localparam int CNT_W  = clog2_p1(STARVE_LIMIT);

  arb_state_t        state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [CNT_W-1:0]  starve_cnt, starve_n, starve_nxt;
  logic              gnt, gnt_n, grant, we_q, we_n;
  logic              en_n, mwe_n, if_ack_n, d_ack_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, if_rdata_n, d_rdata_n;

  pmips_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_prio (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant      (grant),
    .starve_nxt (starve_nxt)
  );

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  always_comb begin
    state_n    = state;
    wait_n     = wait_cnt;
    starve_n   = starve_cnt;
    gnt_n      = gnt;
    we_n       = we_q;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    en_n       = 1'b0;
    mwe_n      = 1'b0;
    if_ack_n   = 1'b0;
    d_ack_n    = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_n    = grant;
          starve_n = starve_nxt;
          if (grant == GNT_D) begin
            we_n    = d_we;
            addr_n  = d_addr;
            wdata_n = d_wdata;
          end else begin
            we_n   = 1'b0;
            addr_n = if_addr;
          end
          en_n    = 1'b1;
          mwe_n   = (grant == GNT_D) && d_we;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wait_n  = WAIT_W'(MEM_LATENCY);
        state_n = WAIT;
      end
      WAIT: begin
        wait_n = wait_cnt - WAIT_W'(1);
        // Last wait cycle: mem_rdata is valid now, ack shows next cycle.
        if (wait_cnt == WAIT_W'(1)) begin
          if (gnt == GNT_IF)
            if_rdata_n = mem_rdata;
          else if (!we_q)
            d_rdata_n = mem_rdata;
          if_ack_n = (gnt == GNT_IF);
          d_ack_n  = (gnt == GNT_D);
          state_n  = RESP;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      gnt        <= GNT_IF;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      starve_cnt <= starve_n;
      gnt        <= gnt_n;
      we_q       <= we_n;
      mem_en     <= en_n;
      mem_we     <= mwe_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      if_ack     <= if_ack_n;
      d_ack      <= d_ack_n;
      if_rdata   <= if_rdata_n;
      d_rdata    <= d_rdata_n;
    end
  end

`ifdef PMIPS_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_if_stall_cnt <= '0;
      perf_d_stall_cnt  <= '0;
    end else begin
      if (if_stall && (perf_if_stall_cnt != 16'hFFFF))
        perf_if_stall_cnt <= perf_if_stall_cnt + 16'd1;
      if (d_stall && (perf_d_stall_cnt != 16'hFFFF))
        perf_d_stall_cnt <= perf_d_stall_cnt + 16'd1;
    end
  end
`else
  assign perf_if_stall_cnt = '0;
  assign perf_d_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// tb/tb_pmips_mem_arbiter.sv - directed self-checking bench for pmips_mem_arbiter
module tb_pmips_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        if_req, d_req, d_we, if_ack, d_ack, mem_en, mem_we, if_stall, d_stall;
  logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, perf_if, perf_d;

  logic        b_if_req, b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_if_stall, b_d_stall;
  logic [15:0] b_if_addr, b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_perf_if, b_perf_d;

  pmips_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall),
    .perf_if_stall_cnt(perf_if), .perf_d_stall_cnt(perf_d)
  );

  pmips_mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(2)) dut_l3 (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .if_stall(b_if_stall), .d_stall(b_d_stall),
    .perf_if_stall_cnt(b_perf_if), .perf_d_stall_cnt(b_perf_d)
  );

  // Latency-1 memory: read data valid only in the cycle after mem_en.
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  logic        rd_v;

  function automatic logic [15:0] init_word(input int a);
    if (a == 16) return 16'h6A83;
    if (a >= 32 && a < 44 && (a % 2) == 0) return 16'h1000 + 16'((a - 32) / 2);
    return 16'h0000;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      rd_v <= 1'b0;
      rd_q <= 16'h0000;
    end else begin
      rd_v <= mem_en & ~mem_we;
      rd_q <= mem[mem_addr[7:0]];
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_v ? rd_q : 16'hDEAD;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  logic exp_if;
  int   dn;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_rdata = 16'hDEAD;
    cyc(); cyc(); smp();
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    chk1("rst_b_mem_en", b_mem_en, 1'b0);
    cyc(); reset = 1'b0;

    // Lone fetch
    cyc(); if_req = 1'b1; if_addr = 16'h0010; smp();
    chk1("f_stall_c0", if_stall, 1'b1);
    chk1("f_en_c0", mem_en, 1'b0);
    cyc(); smp();
    chk1("f_en_c1", mem_en, 1'b1);
    chk("f_addr_c1", mem_addr, 16'h0010);
    chk1("f_stall_c1", if_stall, 1'b1);
    cyc(); smp();
    chk1("f_en_c2", mem_en, 1'b0);
    chk1("f_ack_c2", if_ack, 1'b0);
    chk1("f_stall_c2", if_stall, 1'b1);
    cyc(); smp();
    chk1("f_ack_c3", if_ack, 1'b1);
    chk("f_rdata_c3", if_rdata, 16'h6A83);
    chk1("f_stall_c3", if_stall, 1'b0);
    cyc(); if_req = 1'b0; smp();
    chk1("f_ack_c4", if_ack, 1'b0);

    // Store then load
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; smp();
    chk1("st_stall_c0", d_stall, 1'b1);
    cyc(); smp();
    chk1("st_en_c1", mem_en, 1'b1);
    chk1("st_we_c1", mem_we, 1'b1);
    chk("st_addr_c1", mem_addr, 16'h0040);
    chk("st_wdata_c1", mem_wdata, 16'hBEEF);
    cyc(); smp();
    chk1("st_we_c2", mem_we, 1'b0);
    cyc(); smp();
    chk1("st_ack_c3", d_ack, 1'b1);
    chk("st_rdata_kept", d_rdata, 16'h0000);
    cyc(); d_req = 1'b0; d_we = 1'b0; smp();
    cyc(); d_req = 1'b1; d_addr = 16'h0040; smp();
    cyc(); smp();
    chk1("ld_we_c1", mem_we, 1'b0);
    cyc(); smp();
    cyc(); smp();
    chk1("ld_ack_c3", d_ack, 1'b1);
    chk("ld_rdata_c3", d_rdata, 16'hBEEF);
    chk("ld_if_rdata_kept", if_rdata, 16'h6A83);
    cyc(); d_req = 1'b0; smp();

    // Contention: data first, IF at the following IDLE
    cyc(); if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0040; smp();
    cyc(); smp();
    chk("ct_addr_c1", mem_addr, 16'h0040);
    cyc(); smp();
    cyc(); smp();
    chk1("ct_dack_c3", d_ack, 1'b1);
    chk1("ct_iack_c3", if_ack, 1'b0);
    chk1("ct_istall_c3", if_stall, 1'b1);
    cyc(); d_req = 1'b0; smp();
    cyc(); smp();
    chk("ct_addr_c5", mem_addr, 16'h0010);
    cyc(); smp();
    cyc(); smp();
    chk1("ct_iack_c7", if_ack, 1'b1);
    chk("ct_irdata_c7", if_rdata, 16'h6A83);
    cyc(); if_req = 1'b0; smp();

    // Starvation: expected grant order D, D, IF, D, D, IF
    cyc(); if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0020; dn = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(); cyc(); cyc(); smp();
      exp_if = (k == 2) || (k == 5);
      chk1($sformatf("sv_if_ack_%0d", k), if_ack, exp_if);
      chk1($sformatf("sv_d_ack_%0d", k), d_ack, !exp_if);
      if (!exp_if) begin
        chk($sformatf("sv_d_rdata_%0d", k), d_rdata, 16'h1000 + 16'(dn));
        dn++;
      end
      cyc();
      if (!exp_if) d_addr = 16'h0020 + 16'(2 * dn);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Latency 3: mem_rdata driven only in its valid cycle
    cyc(); b_if_req = 1'b1; b_if_addr = 16'h0100; smp();
    cyc(); smp();
    chk1("l3_en_c1", b_mem_en, 1'b1);
    chk("l3_addr_c1", b_mem_addr, 16'h0100);
    cyc(); smp();
    cyc(); smp();
    chk1("l3_ack_c3", b_if_ack, 1'b0);
    cyc(); b_mem_rdata = 16'h5A5A; smp();
    chk1("l3_ack_c4", b_if_ack, 1'b0);
    cyc(); b_mem_rdata = 16'hDEAD; smp();
    chk1("l3_ack_c5", b_if_ack, 1'b1);
    chk("l3_rdata_c5", b_if_rdata, 16'h5A5A);
    cyc(); b_if_req = 1'b0; smp();
    chk1("l3_ack_c6", b_if_ack, 1'b0);

    // Reset during WAIT of a fetch
    cyc(); if_req = 1'b1; if_addr = 16'h0020; smp();
    cyc(); smp();
    cyc(); reset = 1'b1; if_req = 1'b0; smp();
    cyc(); smp();
    chk1("rw_if_ack", if_ack, 1'b0);
    chk1("rw_d_ack", d_ack, 1'b0);
    chk1("rw_mem_en", mem_en, 1'b0);
    chk1("rw_mem_we", mem_we, 1'b0);
    chk("rw_mem_addr", mem_addr, 16'h0000);
    chk("rw_mem_wdata", mem_wdata, 16'h0000);
    chk("rw_if_rdata", if_rdata, 16'h0000);
    chk("rw_d_rdata", d_rdata, 16'h0000);
    chk1("rw_if_stall", if_stall, 1'b0);
    chk("rw_perf_if", perf_if, 16'h0000);
    chk("rw_perf_d", perf_d, 16'h0000);
    cyc(); reset = 1'b0; smp();
    chk1("rw_if_ack_c4", if_ack, 1'b0);
    cyc(); smp();
    chk1("rw_if_ack_c5", if_ack, 1'b0);
    chk1("rw_mem_en_c5", mem_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
